data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store bundle between the memory stage and the data-memory responder.
// The master raises requests; the slave returns data, a ready strobe and status.
interface data_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              misaligned;
  logic              busy;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, ready, misaligned, busy
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, ready, misaligned, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle ready strobe.
// Misaligned requests complete with the same latency but never touch the array.
//
// state  | meaning
// S_IDLE | waiting for memread/memwrite; a request is captured here
// S_WAIT | counting wait states; the array is accessed on the exit edge
// S_RESP | ready high for one cycle, misaligned qualifies it
module data_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // S_WAIT holds WAIT+1 cycles: the accept cycle after sampling plus WAIT wait states.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              is_wr_q, is_wr_d;
  logic              mis_q, mis_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              req;
  logic              commit;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  assign req    = bus.memread | bus.memwrite;
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we = commit && is_wr_q && !mis_q;
  assign mem_rd = mem_q[idx_q];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_addr_wrap
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
      mis_q   <= mis_d;
    end
  end

  // Storage is not reset; a reset before the commit edge leaves state_q out of S_WAIT.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = S_WAIT;
      S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    if ((state_q == S_IDLE) && req) begin
      cnt_d   = CNT_LOAD;
      idx_d   = bus.addr[IDX_W+1:2];
      wdata_d = bus.wdata;
      is_wr_d = bus.memwrite;
      mis_d   = (bus.addr[1:0] != 2'b00);
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    // Stores leave rdata alone; misaligned responses clear it.
    if (commit) begin
      if (mis_q) begin
        rdata_d = '0;
      end else if (!is_wr_q) begin
        rdata_d = mem_rd;
      end
    end
  end

  always_comb begin
    bus.ready      = (state_q == S_RESP);
    bus.misaligned = (state_q == S_RESP) && mis_q;
    bus.busy       = (state_q != S_IDLE);
    bus.rdata      = rdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with WAIT=1, DEPTH=256.
// Expected values are hand-computed constants.
module tb_data_mem_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int WAIT   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .WAIT  (WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called one step after a rising edge with the DUT idle; returns one step after
  // the edge that ends the response cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat,
                        output logic mis, output int lat);
    bus.memwrite = wr;
    bus.memread  = rd;
    bus.addr     = a;
    bus.wdata    = wd;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    bus.memread  = 1'b0;
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
    lat  = 99;
    rdat = '0;
    mis  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        lat  = i;
        rdat = bus.rdata;
        mis  = bus.misaligned;
        break;
      end
    end
    if (lat != 99) begin
      @(posedge clk);
      #1;
      check("ready_one_cycle", 32'(bus.ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          pulses;

    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_misaligned", 32'(bus.misaligned), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, mis, lat);
    check("st10_latency", 32'(lat), 32'd2);
    check("st10_misaligned", 32'(mis), 32'd0);
    check("st10_rdata_kept", rd, 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'h0, rd, mis, lat);
    check("ld10_latency", 32'(lat), 32'd2);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_misaligned", 32'(mis), 32'd0);

    access(1'b0, 1'b1, 32'h13, 32'h0, rd, mis, lat);
    check("ld13_latency", 32'(lat), 32'd2);
    check("ld13_misaligned", 32'(mis), 32'd1);
    check("ld13_rdata", rd, 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'h0, rd, mis, lat);
    check("ld10_again_rdata", rd, 32'hDEADBEEF);

    access(1'b1, 1'b1, 32'h20, 32'h12345678, rd, mis, lat);
    check("both20_latency", 32'(lat), 32'd2);
    check("both20_rdata_kept", rd, 32'hDEADBEEF);
    check("both20_misaligned", 32'(mis), 32'd0);
    access(1'b0, 1'b1, 32'h20, 32'h0, rd, mis, lat);
    check("ld20_rdata", rd, 32'h12345678);

    access(1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, rd, mis, lat);
    access(1'b0, 1'b1, 32'h0, 32'h0, rd, mis, lat);
    check("wrap_ld0_latency", 32'(lat), 32'd2);
    check("wrap_ld0_rdata", rd, 32'hA5A5A5A5);
    access(1'b0, 1'b1, 32'h10, 32'h0, rd, mis, lat);
    check("wrap_ld10_untouched", rd, 32'hDEADBEEF);

    // memread held across edges 0..11: samples at 0, 4, 8.
    pulses = 0;
    bus.memread = 1'b1;
    bus.addr    = 32'h20;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 11) bus.memread = 1'b0;
      check($sformatf("held_ready_c%0d", i), 32'(bus.ready),
            32'((i < 12) && (i % 4 == 2)));
      check($sformatf("held_busy_c%0d", i), 32'(bus.busy),
            32'((i < 12) && (i % 4 != 3)));
      pulses += int'(bus.ready);
    end
    check("held_pulse_count", 32'(pulses), 32'd3);
    check("held_rdata", bus.rdata, 32'h12345678);

    access(1'b1, 1'b0, 32'h8, 32'h0, rd, mis, lat);
    check("st8_zero_latency", 32'(lat), 32'd2);
    bus.memwrite = 1'b1;
    bus.addr     = 32'h8;
    bus.wdata    = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    check("abort_busy_after_sample", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_misaligned", 32'(bus.misaligned), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_hold_ready_c%0d", i), 32'(bus.ready), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort_post_ready_c%0d", i), 32'(bus.ready), 32'd0);
      check($sformatf("abort_post_busy_c%0d", i), 32'(bus.busy), 32'd0);
    end
    access(1'b0, 1'b1, 32'h8, 32'h0, rd, mis, lat);
    check("ld8_latency", 32'(lat), 32'd2);
    check("ld8_no_commit", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
